// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiply issue stage, the multiplier array and
// the decoder: op encodings, FSM state encoding and the default tag width.
package mul_issue_ctrl_pkg;

  // One-hot multiply op encodings seen by the array.
  localparam int MUL_OP_W = 3;
  localparam logic [MUL_OP_W-1:0] MULW   = 3'b001;  // low 32 bits of product
  localparam logic [MUL_OP_W-1:0] MULHW  = 3'b010;  // signed high 32 bits
  localparam logic [MUL_OP_W-1:0] MULHWU = 3'b100;  // unsigned high 32 bits

  // Destination tag width used when the parent does not override it.
  localparam int DEFAULT_TAG_W = 5;

  // Issue FSM state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ISSUE  = ST_ISSUE,
    RESULT = ST_RESULT,
    HOLD   = ST_HOLD
  } mul_state_t;

  // Force an arbitrary request op onto a legal one-hot encoding so the array
  // never sees an ambiguous select. mul.w wins, then mulh.wu, and anything
  // else (including all-zero) falls back to mulh.w.
  function automatic logic [MUL_OP_W-1:0] canon_op(input logic [MUL_OP_W-1:0] op);
    logic [MUL_OP_W-1:0] res;
    casez (op)
      3'b??1:  res = MULW;
      3'b1?0:  res = MULHWU;
      default: res = MULHW;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_out_hold.sv
// Result hold buffer: captures the array product and its tag when MEM stalls
// so the array inputs are free to change, and muxes live/held data onto the
// outgoing result.
module mul_out_hold
  import mul_issue_ctrl_pkg::*;
#(
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             mul_clk,
  input  logic             reset,
  input  logic             load,
  input  logic             sel_hold,
  input  logic [31:0]      live_result,
  input  logic [TAG_W-1:0] live_tag,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  logic [31:0]      hold_result_reg;
  logic [TAG_W-1:0] hold_tag_reg;

  // Capture the product and tag on the cycle the result was refused.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      hold_result_reg <= '0;
      hold_tag_reg    <= '0;
    end else if (load) begin
      hold_result_reg <= live_result;
      hold_tag_reg    <= live_tag;
    end
  end

  // Once stalled, the outgoing word comes only from the buffer.
  always_comb begin
    out_result = live_result;
    out_tag    = live_tag;
    if (sel_hold) begin
      out_result = hold_result_reg;
      out_tag    = hold_tag_reg;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiply issue/retire sequencer around the 1-cycle Booth/Wallace array.
// Accepts one op from EXE, holds operands steady for the array, presents the
// product to MEM with back-pressure buffering, and reports the in-flight tag
// to ID for hazard detection.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic                mul_clk,
  input  logic                reset,
  input  logic                flush,
  // request from EXE
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [31:0]         in_x,
  input  logic [31:0]         in_y,
  input  logic [TAG_W-1:0]    in_tag,
  // array interface
  output logic [MUL_OP_W-1:0] mul_op,
  output logic [31:0]         mul_x,
  output logic [31:0]         mul_y,
  input  logic [31:0]         mul_result,
  // result to MEM
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic [TAG_W-1:0]    out_tag,
  // hazard report to ID
  output logic                busy,
  output logic [TAG_W-1:0]    busy_tag
);

  mul_state_t          state_reg;
  logic [MUL_OP_W-1:0] op_reg;
  logic [31:0]         x_reg;
  logic [31:0]         y_reg;
  logic [TAG_W-1:0]    tag_reg;

  // Registered decodes of the state, kept alongside it so the handshake
  // outputs only add the flush/out_ready gating on top of a flop.
  logic                idle_reg;
  logic                valid_reg;
  logic                busy_reg;

  logic                accept;
  logic                hold_load;
  logic                hold_sel;

  // A new request may enter while idle, or on the very cycle the current
  // result retires, so back-to-back ops lose no extra cycle.
  always_comb begin
    in_ready  = ~flush & (idle_reg | (valid_reg & out_ready));
    out_valid = valid_reg & ~flush;
    accept    = in_valid & in_ready;
    busy      = busy_reg;
    busy_tag  = tag_reg;
    mul_op    = op_reg;
    mul_x     = x_reg;
    mul_y     = y_reg;
  end

  // The array result is only valid in RESULT; if MEM refuses it there, park
  // it in the buffer because the array output is not guaranteed afterwards.
  always_comb begin
    hold_load = (state_reg == RESULT) & ~out_ready & ~flush;
    hold_sel  = (state_reg == HOLD);
  end

  // Issue FSM with operand/tag registers and registered state decodes.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      tag_reg   <= '0;
      idle_reg  <= 1'b1;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else if (flush) begin
      // Kill whatever is in flight; operand registers become don't-care.
      state_reg <= IDLE;
      idle_reg  <= 1'b1;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      // Operands only change on an accept, which keeps the array inputs
      // stable from the accept edge through the RESULT cycle.
      if (accept) begin
        op_reg  <= canon_op(in_op);
        x_reg   <= in_x;
        y_reg   <= in_y;
        tag_reg <= in_tag;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= ISSUE;
            idle_reg  <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        ISSUE: begin
          // Array captures mul_* at the end of this cycle.
          state_reg <= RESULT;
          valid_reg <= 1'b1;
        end
        RESULT, HOLD: begin
          if (out_ready) begin
            valid_reg <= 1'b0;
            if (accept) begin
              state_reg <= ISSUE;
              idle_reg  <= 1'b0;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= IDLE;
              idle_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end
          end else begin
            state_reg <= HOLD;
          end
        end
        default: begin
          state_reg <= IDLE;
          idle_reg  <= 1'b1;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  mul_out_hold #(
    .TAG_W(TAG_W)
  ) u_out_hold (
    .mul_clk     (mul_clk),
    .reset       (reset),
    .load        (hold_load),
    .sel_hold    (hold_sel),
    .live_result (mul_result),
    .live_tag    (tag_reg),
    .out_result  (out_result),
    .out_tag     (out_tag)
  );

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl: directed scenarios plus randomized
// traffic, checked against a cycle-count based model of the handshake rules
// and a 64-bit arithmetic reference for the products.
module tb_mul_issue_ctrl;

  localparam int TAG_W = 5;

  logic             mul_clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [31:0]      in_x;
  logic [31:0]      in_y;
  logic [TAG_W-1:0] in_tag;
  logic [2:0]       mul_op;
  logic [31:0]      mul_x;
  logic [31:0]      mul_y;
  logic [31:0]      mul_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [TAG_W-1:0] busy_tag;

  mul_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_tag     (in_tag),
    .mul_op     (mul_op),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy),
    .busy_tag   (busy_tag)
  );

  always #5 mul_clk = ~mul_clk;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [2:0]       op;
    logic [31:0]      x;
    logic [31:0]      y;
    int               acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   last_acc = 0;

  // Product of the request as the architecture defines it.
  function automatic logic [31:0] ref_mul(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    longint sp;
    logic [63:0] up;
    sp = longint'($signed(x)) * longint'($signed(y));
    up = 64'(x) * 64'(y);
    if (op[0]) return up[31:0];
    if (op[2]) return up[63:32];
    return sp[63:32];
  endfunction

  function automatic logic [2:0] ref_op(input logic [2:0] op);
    if (op[0]) return 3'b001;
    if (op[2]) return 3'b100;
    return 3'b010;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Stand-in array: produces a real product only for the op whose ISSUE cycle
  // just ended, junk otherwise, so a missing hold buffer cannot go unnoticed.
  always @(posedge mul_clk) begin
    if (q.size() > 0 && cyc == q[0].acc + 1) begin
      case (mul_op)
        3'b001:  mul_result <= ref_mul(3'b001, mul_x, mul_y);
        3'b010:  mul_result <= ref_mul(3'b010, mul_x, mul_y);
        3'b100:  mul_result <= ref_mul(3'b100, mul_x, mul_y);
        default: mul_result <= $urandom;
      endcase
    end else begin
      mul_result <= $urandom;
    end
    cyc <= cyc + 1;
  end

  // Monitor: checks handshake/hazard outputs every cycle and retires results.
  always @(negedge mul_clk) begin
    if (mon_en) begin
      logic exp_ov;
      logic exp_rdy;
      exp_ov  = (q.size() > 0) && !flush && (cyc >= q[0].acc + 2);
      exp_rdy = !flush && ((q.size() == 0) || (exp_ov && out_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("busy_tag", 32'(busy_tag), 32'(q[0].tag));
        if (cyc == q[0].acc + 1 || cyc == q[0].acc + 2) begin
          chk("mul_op", 32'(mul_op), 32'(q[0].op));
          chk("mul_x", mul_x, q[0].x);
          chk("mul_y", mul_y, q[0].y);
        end
      end
      if (exp_ov && out_valid) begin
        chk("out_result", out_result, q[0].res);
        chk("out_tag", 32'(out_tag), 32'(q[0].tag));
        if (out_ready) begin
          $display("retire tag=%0d result=%h cyc=%0d", out_tag, out_result, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; records accepts/flushes into the scoreboard.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [TAG_W-1:0] t,
                      input logic ordy, input logic fl);
    exp_t e;
    @(posedge mul_clk);
    #1;
    in_valid = v; in_op = op; in_x = x; in_y = y; in_tag = t;
    out_ready = ordy; flush = fl;
    @(negedge mul_clk);
    #1;
    last_acc = 0;
    if (flush) q.delete();
    if (in_valid && in_ready && !flush) begin
      e.res = ref_mul(in_op, in_x, in_y);
      e.tag = in_tag;
      e.op  = ref_op(in_op);
      e.x   = in_x;
      e.y   = in_y;
      e.acc = cyc;
      q.push_back(e);
      last_acc = 1;
      $display("accept op=%b x=%h y=%h tag=%0d cyc=%0d", in_op, in_x, in_y, in_tag, cyc);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [TAG_W-1:0] t, input logic ordy);
    int n;
    n = 0;
    do begin
      step(1'b1, op, x, y, t, ordy, 1'b0);
      n++;
    end while (!last_acc && n < 20);
    chk("accept_timeout", 32'(last_acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 3'($urandom), $urandom, $urandom, '0, ordy, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      idle(1, 1'b1);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0;
    in_tag = '0; out_ready = 1'b1;
    #23;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mul_op", 32'(mul_op), 32'd0);
    chk("rst_mul_x", mul_x, 32'd0);
    chk("rst_busy_tag", 32'(busy_tag), 32'd0);
    @(posedge mul_clk); #1 reset = 1'b0;
    mon_en = 1;

    // basic mul.w
    send(3'b001, 32'd7, 32'd6, 5'd3, 1'b1);
    drain();
    // back-to-back all-ones, three ops
    send(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1);
    send(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b1);
    send(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1'b1);
    drain();
    // back-pressure into HOLD with toggling inputs
    send(3'b010, 32'h80000000, 32'h80000000, 5'd9, 1'b0);
    idle(4, 1'b0);
    drain();
    // flush in ISSUE, then a normal op
    send(3'b001, 32'd5, 32'd5, 5'd7, 1'b1);
    step(1'b0, 3'b001, 32'd0, 32'd0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);
    send(3'b001, 32'd11, 32'd13, 5'd8, 1'b1);
    drain();
    // flush in HOLD, then a normal op
    send(3'b100, 32'h12345678, 32'h9ABCDEF0, 5'd10, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 3'b001, 32'd0, 32'd0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);
    send(3'b010, 32'hFFFFFFFE, 32'd3, 5'd11, 1'b1);
    drain();
    // op canonicalisation
    send(3'b000, 32'hDEADBEEF, 32'h00010001, 5'd12, 1'b1);
    send(3'b011, 32'hDEADBEEF, 32'h00010001, 5'd13, 1'b1);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      rx = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      step(1'($urandom_range(0, 1)), 3'($urandom), rx, ry, TAG_W'($urandom),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 15) == 0));
    end
    drain();

    // asynchronous reset in the RESULT cycle
    send(3'b001, 32'd100, 32'd200, 5'd14, 1'b0);
    idle(1, 1'b0);
    @(posedge mul_clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    #2;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    mon_en = 0;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_mul_x", mul_x, 32'd0);
    q.delete();
    @(posedge mul_clk); #1 reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    mon_en = 1;
    send(3'b100, 32'hFFFFFFFF, 32'd2, 5'd15, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
